ex_mem_skid_reg: RTL and testbench

//   EX/MEM pipeline boundary for the MIPS pipeline, directly downstream of the Execute-stage

---
 rtl/ex_mem_skid_reg.sv | 87 ++++++++
 tb/tb_ex_mem_skid_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX/MEM two-entry skid buffer with PCSrc decision.
// Optional stall counter enabled by defining EXMEM_STALL_CNT_EN.
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ex_branch_tgt,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_wreg,
  input  logic [CTRL_W-1:0] ex_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_branch_tgt,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic              mem_zero,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_W-1:0]  mem_wreg,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic              mem_pcsrc
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int P_W = 3 * DATA_W + 1 + REG_W + CTRL_W;

  logic           main_valid;
  logic           skid_valid;
  logic [P_W-1:0] main_data;
  logic [P_W-1:0] skid_data;
  logic [P_W-1:0] in_data;
  logic           accept;
  logic           drain;

  assign in_data = {ex_branch_tgt, ex_alu_result, ex_zero, ex_wdata, ex_wreg, ex_ctrl};
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & ~skid_valid;
  assign drain    = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so the only possible move is skid -> main
      if (drain) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || drain) begin
      main_valid <= accept;
      if (accept) main_data <= in_data;
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign {mem_branch_tgt, mem_alu_result, mem_zero, mem_wdata, mem_wreg, mem_ctrl} = main_data;
  assign mem_pcsrc = main_valid & mem_ctrl[2] & mem_zero;

`ifdef EXMEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (main_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - directed self-checking bench for ex_mem_skid_reg.
module tb_ex_mem_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_branch_tgt;
  logic [31:0] ex_alu_result;
  logic        ex_zero;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_wreg;
  logic [4:0]  ex_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mem_branch_tgt;
  logic [31:0] mem_alu_result;
  logic        mem_zero;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_wreg;
  logic [4:0]  mem_ctrl;
  logic        mem_pcsrc;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  ex_mem_skid_reg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ex_branch_tgt  (ex_branch_tgt),
    .ex_alu_result  (ex_alu_result),
    .ex_zero        (ex_zero),
    .ex_wdata       (ex_wdata),
    .ex_wreg        (ex_wreg),
    .ex_ctrl        (ex_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mem_branch_tgt (mem_branch_tgt),
    .mem_alu_result (mem_alu_result),
    .mem_zero       (mem_zero),
    .mem_wdata      (mem_wdata),
    .mem_wreg       (mem_wreg),
    .mem_ctrl       (mem_ctrl),
    .mem_pcsrc      (mem_pcsrc)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] tgt, input logic [31:0] alu,
                       input logic z, input logic [31:0] wd, input logic [4:0] wr,
                       input logic [4:0] c);
    in_valid      = v;
    ex_branch_tgt = tgt;
    ex_alu_result = alu;
    ex_zero       = z;
    ex_wdata      = wd;
    ex_wreg       = wr;
    ex_ctrl       = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_pcsrc !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got v=%b r=%b pc=%b exp 0 1 0", out_valid, in_ready, mem_pcsrc);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if ({mem_branch_tgt, mem_alu_result, mem_zero, mem_wdata, mem_wreg, mem_ctrl} !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload got tgt=%h alu=%h wd=%h wr=%h c=%b exp all 0",
               mem_branch_tgt, mem_alu_result, mem_wdata, mem_wreg, mem_ctrl);
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle got v=%b r=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0040, 32'd30, 1'b1, 32'h0000_0055, 5'd3, 5'b00100);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    tests_run++;
    if (out_valid !== 1'b1 || mem_alu_result !== 32'd30 || mem_pcsrc !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_main got v=%b alu=%0d pc=%b exp 1 30 1", out_valid, mem_alu_result, mem_pcsrc);
    end
    tests_run++;
    if (mem_branch_tgt !== 32'h40 || mem_wdata !== 32'h55 || mem_wreg !== 5'd3 || mem_ctrl !== 5'b00100 || mem_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_fields got tgt=%h wd=%h wr=%0d c=%b z=%b exp 40 55 3 00100 1",
               mem_branch_tgt, mem_wdata, mem_wreg, mem_ctrl, mem_zero);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || mem_pcsrc !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain got v=%b pc=%b exp 0 0", out_valid, mem_pcsrc);
    end
  endtask

  task automatic test_full_width();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 1'b0, 32'hDEAD_BEEF, 5'd31, 5'b11011);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    tests_run++;
    if (mem_branch_tgt !== 32'hFFFF_FFFF || mem_alu_result !== 32'hA5A5_5A5A || mem_wdata !== 32'hDEAD_BEEF ||
        mem_wreg !== 5'd31 || mem_ctrl !== 5'b11011 || mem_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_width got tgt=%h alu=%h wd=%h wr=%0d c=%b z=%b exp ffffffff a5a55a5a deadbeef 31 11011 0",
               mem_branch_tgt, mem_alu_result, mem_wdata, mem_wreg, mem_ctrl, mem_zero);
    end
    tests_run++;
    if (mem_pcsrc !== 1'b0) begin
      tests_failed++;
      $display("FAIL pcsrc_branch_nozero got %b exp 0", mem_pcsrc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'd10, 1'b0, 32'h1, 5'd1, 5'b00100);
    step();
    tests_run++;
    if (out_valid !== 1'b1 || mem_alu_result !== 32'd10 || in_ready !== 1'b1 || mem_pcsrc !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_a got v=%b alu=%0d r=%b pc=%b exp 1 10 1 0", out_valid, mem_alu_result, in_ready, mem_pcsrc);
    end
    drive(1'b1, 32'h200, 32'd20, 1'b1, 32'h2, 5'd2, 5'b10000);
    step();
    tests_run++;
    if (out_valid !== 1'b1 || mem_alu_result !== 32'd10 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_skid got v=%b alu=%0d r=%b exp 1 10 0", out_valid, mem_alu_result, in_ready);
    end
    drive(1'b1, 32'h300, 32'd99, 1'b0, 32'h3, 5'd3, 5'b00000);
    step();
    tests_run++;
    if (mem_alu_result !== 32'd10 || mem_branch_tgt !== 32'h100 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_hold got alu=%0d tgt=%h r=%b exp 10 100 0", mem_alu_result, mem_branch_tgt, in_ready);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || mem_alu_result !== 32'd20 || mem_wreg !== 5'd2 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_b got v=%b alu=%0d wr=%0d r=%b exp 1 20 2 1", out_valid, mem_alu_result, mem_wreg, in_ready);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_empty got v=%b r=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'd11, 1'b1, 32'h0, 5'd4, 5'b00100);
    step();
    drive(1'b1, 32'h0, 32'd12, 1'b1, 32'h0, 5'd5, 5'b00100);
    step();
    tests_run++;
    if (in_ready !== 1'b0 || mem_alu_result !== 32'd11) begin
      tests_failed++;
      $display("FAIL flush_prefill got r=%b alu=%0d exp 0 11", in_ready, mem_alu_result);
    end
    drive(1'b1, 32'h0, 32'd7, 1'b1, 32'h0, 5'd6, 5'b00100);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_pcsrc !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear got v=%b r=%b pc=%b exp 0 1 0", out_valid, in_ready, mem_pcsrc);
    end
    out_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_c got v=%b alu=%0d exp v=0", out_valid, mem_alu_result);
    end
    drive(1'b1, 32'h0, 32'd5, 1'b0, 32'h0, 5'd7, 5'b00000);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    tests_run++;
    if (out_valid !== 1'b1 || mem_alu_result !== 32'd5) begin
      tests_failed++;
      $display("FAIL flush_recover got v=%b alu=%0d exp 1 5", out_valid, mem_alu_result);
    end
    step();
  endtask

  task automatic test_stream();
    int errs;
    errs = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h0, i, 1'b0, 32'h0, 5'd0, 5'b00000);
      step();
      tests_run++;
      if (out_valid !== 1'b1 || mem_alu_result !== i || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d got v=%b alu=%0d r=%b exp 1 %0d 1", i, out_valid, mem_alu_result, in_ready, i);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end got v=%b exp 0", out_valid);
    end
  endtask

`ifdef EXMEM_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tests_run++;
    if (stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL stall_reset got %0d exp 0", stall_cnt);
    end
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'd42, 1'b0, 32'h0, 5'd1, 5'b00000);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0, 5'h0);
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (stall_cnt !== 32'd5 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_count got cnt=%0d v=%b exp 5 1", stall_cnt, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (stall_cnt !== 32'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_async_rst got cnt=%0d v=%b exp 0 0", stall_cnt, out_valid);
    end
    rst_n = 1'b1;
    step();
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_full_width();
    test_back_to_back();
    test_flush();
    test_stream();
`ifdef EXMEM_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
